// File: rtl/lmul_uop_sequencer.sv
// Splits one LMUL-grouped vector instruction into LMUL single-register micro-ops.
// Optional legality checking is compiled in with `define VREG_GROUP_CHECK_EN.
module lmul_uop_sequencer #(
    parameter int MAX_LMUL = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_vs1,
    input  logic [4:0] in_vs2,
    input  logic [4:0] in_vd,
    input  logic [2:0] in_lmul,
    output logic       uop_valid,
    input  logic       uop_ready,
    output logic [4:0] uop_vs1,
    output logic [4:0] uop_vs2,
    output logic [4:0] uop_vd,
    output logic [2:0] uop_idx,
    output logic       uop_last,
    output logic       fe_stall,
    output logic       illegal,
    output logic       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready depends combinationally on uop_ready so the next group can be
    // accepted in the same cycle as the last micro-op of the current one.

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [3:0] MAX_L = 4'(MAX_LMUL);

    state_t     state_q, state_d;
    logic [4:0] vs1_q, vs2_q, vd_q;
    logic [4:0] vs1_d, vs2_d, vd_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] rem_q, rem_d;
    logic       illegal_q, illegal_d;

    logic [3:0] lmul_raw;
    logic [3:0] lmul_eff;
    logic       instr_bad;
    logic       accept;
    logic       handshake;

    // Reserved encodings fall back to a single register.
    always_comb begin
        case (in_lmul)
            3'b000:  lmul_raw = 4'd1;
            3'b001:  lmul_raw = 4'd2;
            3'b010:  lmul_raw = 4'd4;
            3'b011:  lmul_raw = 4'd8;
            default: lmul_raw = 4'd1;
        endcase
        lmul_eff = (lmul_raw > MAX_L) ? MAX_L : lmul_raw;
    end

`ifdef VREG_GROUP_CHECK_EN
    logic [4:0] align_mask;
    assign align_mask = 5'(lmul_raw - 4'd1);
    assign instr_bad  = in_lmul[2] || (lmul_raw > MAX_L) ||
                        (|((in_vs1 | in_vs2 | in_vd) & align_mask));
`else
    assign instr_bad = 1'b0;
`endif

    assign uop_valid = (state_q == ISSUE);
    assign uop_last  = (rem_q == 3'd0);
    assign handshake = uop_valid && uop_ready;
    assign in_ready  = (state_q == IDLE) || (handshake && uop_last);
    assign accept    = in_valid && in_ready;
    assign fe_stall  = !in_ready;
    assign uop_vs1   = vs1_q;
    assign uop_vs2   = vs2_q;
    assign uop_vd    = vd_q;
    assign uop_idx   = idx_q;
    assign illegal   = illegal_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        vs1_d     = vs1_q;
        vs2_d     = vs2_q;
        vd_d      = vd_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        illegal_d = 1'b0;
        if (accept) begin
            if (instr_bad) begin
                state_d   = IDLE;
                illegal_d = 1'b1;
            end else begin
                state_d = ISSUE;
                vs1_d   = in_vs1;
                vs2_d   = in_vs2;
                vd_d    = in_vd;
                idx_d   = 3'd0;
                rem_d   = 3'(lmul_eff - 4'd1);
            end
        end else if (handshake) begin
            if (uop_last) begin
                state_d = IDLE;
            end else begin
                // 5-bit register indices wrap 31 -> 0 naturally.
                vs1_d = vs1_q + 5'd1;
                vs2_d = vs2_q + 5'd1;
                vd_d  = vd_q + 5'd1;
                idx_d = idx_q + 3'd1;
                rem_d = rem_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            vs1_q     <= 5'd0;
            vs2_q     <= 5'd0;
            vd_q      <= 5'd0;
            idx_q     <= 3'd0;
            rem_q     <= 3'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs1_q     <= vs1_d;
            vs2_q     <= vs2_d;
            vd_q      <= vd_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_lmul_uop_sequencer.sv
// Self-checking bench for lmul_uop_sequencer: directed scenarios plus random
// instructions, checked against a queue of expected micro-ops.
module tb_lmul_uop_sequencer;

    localparam int MAX_LMUL = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_vs1, in_vs2, in_vd;
    logic [2:0] in_lmul;
    logic       uop_valid;
    logic       uop_ready;
    logic [4:0] uop_vs1, uop_vs2, uop_vd;
    logic [2:0] uop_idx;
    logic       uop_last;
    logic       fe_stall;
    logic       illegal;
    logic       dbg_state;

    int checks = 0;
    int errors = 0;
    int rdy_pct = 100;
    bit ill_due = 1'b0;
    bit acc_due = 1'b0;
    bit acc_legal = 1'b0;
    logic [18:0] exp_q[$];

    lmul_uop_sequencer #(.MAX_LMUL(MAX_LMUL)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_vs1(in_vs1), .in_vs2(in_vs2), .in_vd(in_vd), .in_lmul(in_lmul),
        .uop_valid(uop_valid), .uop_ready(uop_ready),
        .uop_vs1(uop_vs1), .uop_vs2(uop_vs2), .uop_vd(uop_vd),
        .uop_idx(uop_idx), .uop_last(uop_last),
        .fe_stall(fe_stall), .illegal(illegal), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: group size and legality from the instruction encoding
    function automatic int group_size(input logic [2:0] enc);
        int n;
        n = (enc > 3'd3) ? 1 : (1 << enc);
        if (n > MAX_LMUL) n = MAX_LMUL;
        return n;
    endfunction

    function automatic bit is_illegal(input logic [4:0] a, input logic [4:0] b,
                                      input logic [4:0] d, input logic [2:0] enc);
`ifdef VREG_GROUP_CHECK_EN
        int raw;
        if (enc > 3'd3) return 1'b1;
        raw = 1 << enc;
        if (raw > MAX_LMUL) return 1'b1;
        return (int'(a) % raw != 0) || (int'(b) % raw != 0) || (int'(d) % raw != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_group(input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] d, input logic [2:0] enc);
        int n;
        n = group_size(enc);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({5'((int'(a) + i) % 32), 5'((int'(b) + i) % 32),
                             5'((int'(d) + i) % 32), 3'(i), (i == n - 1)});
        end
    endtask

    // driver: called just after a rising edge, returns just after the accepting edge
    task automatic issue(input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic [2:0] enc);
        bit got;
        bit done;
        done = 1'b0;
        in_vs1 = a; in_vs2 = b; in_vd = d; in_lmul = enc; in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            if (got) begin
                done = 1'b1;
                acc_due = 1'b1;
                acc_legal = !is_illegal(a, b, d, enc);
                if (acc_legal) push_group(a, b, d, enc);
                else ill_due = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected acceptance");
        end
        #1;
        in_valid = 1'b0;
        in_vs1 = 5'($urandom); in_vs2 = 5'($urandom);
        in_vd = 5'($urandom); in_lmul = 3'($urandom);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    always @(posedge clk) begin
        #1;
        uop_ready = (int'($urandom_range(0, 99)) < rdy_pct);
    end

    // scoreboard monitor
    logic [18:0] cur_vec, prev_vec;
    bit stall_prev = 1'b0;
    bit exp_rdy;
    always @(negedge clk) begin
        cur_vec = {uop_vs1, uop_vs2, uop_vd, uop_idx, uop_last};
        if (acc_due) begin
            check("uop_valid_after_accept", uop_valid, acc_legal);
            acc_due = 1'b0;
        end
        check("illegal", illegal, ill_due);
        ill_due = 1'b0;
        check("uop_valid", uop_valid, exp_q.size() != 0);
        exp_rdy = (exp_q.size() == 0) || (uop_ready && exp_q.size() == 1);
        check("in_ready", in_ready, exp_rdy);
        check("fe_stall", fe_stall, !exp_rdy);
        if (stall_prev && !rst) check("hold", {uop_valid, cur_vec}, {1'b1, prev_vec});
        if (uop_valid && uop_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL uop: got %0h expected none", cur_vec);
            end else begin
                check("uop", cur_vec, exp_q.pop_front());
            end
        end
        stall_prev = uop_valid && !uop_ready && !rst;
        prev_vec = cur_vec;
    end

    initial begin
        logic [4:0] a, b, d;
        logic [2:0] enc;
        int n;
        bit found;
        rst = 1'b1; in_valid = 1'b0; uop_ready = 1'b0;
        in_vs1 = '0; in_vs2 = '0; in_vd = '0; in_lmul = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_uop_valid", uop_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_fe_stall", fe_stall, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_uop_last", uop_last, 1'b1);
        check("rst_regs", {uop_vs1, uop_vs2, uop_vd, uop_idx}, 18'd0);
        check("rst_state", dbg_state, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        rdy_pct = 100;
        issue(5'd3, 5'd5, 5'd7, 3'b000);
        wait_drain();
        issue(5'd8, 5'd12, 5'd16, 3'b010);
        wait_drain();

        // backpressure on idx 0 for three cycles
        rdy_pct = 0;
        issue(5'd2, 5'd4, 5'd6, 3'b001);
        repeat (3) @(posedge clk);
        rdy_pct = 100;
        wait_drain();

        // back-to-back groups
        issue(5'd10, 5'd12, 5'd14, 3'b001);
        issue(5'd20, 5'd22, 5'd24, 3'b001);
        wait_drain();

        // reset during idx 2 of an LMUL=8 group
        issue(5'd0, 5'd8, 5'd16, 3'b011);
        found = 1'b0;
        for (int t = 0; t < 50 && !found; t++) begin
            @(negedge clk);
            if (uop_valid && uop_idx == 3'd2) found = 1'b1;
        end
        check("reach_idx2", found, 1'b1);
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_uop_valid", uop_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_last_idx", {uop_last, uop_idx}, 4'b1000);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        issue(5'd1, 5'd2, 5'd3, 3'b000);
        wait_drain();

        // misaligned group and register wrap-around
        issue(5'd0, 5'd4, 5'd6, 3'b010);
        wait_drain();
        issue(5'd0, 5'd8, 5'd28, 3'b011);
        wait_drain();
        issue(5'd1, 5'd1, 5'd1, 3'b110);
        wait_drain();

        // random traffic
        for (int k = 0; k < 60; k++) begin
            rdy_pct = int'($urandom_range(30, 100));
            enc = 3'($urandom_range(0, 7));
            a = 5'($urandom); b = 5'($urandom); d = 5'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                n = group_size(enc);
                a = 5'(int'(a) - int'(a) % n);
                b = 5'(int'(b) - int'(b) % n);
                d = 5'(int'(d) - int'(d) % n);
            end
            issue(a, b, d, enc);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        rdy_pct = 100;
        wait_drain();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lmul_uop_sequencer.md
LMUL_UOP_SEQUENCER -- requirements
Module: lmul_uop_sequencer

Interface
REQ-001 The block SHALL have a single clock, with reset asynchronous and active-high.
REQ-002 Parameter: MAX_LMUL, 8, largest supported register-group size (power of two, at most 8).
REQ-003 The block SHALL have the following ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  vector instruction offered.
- in_ready  out  1  sequencer accepts the instruction this cycle.
- in_vs1, in_vs2, in_vd  in  5 each  base register indices of the group.
- in_lmul  in  3  encoded LMUL: 000=1, 001=2, 010=4, 011=8, others reserved.
- uop_valid  out  1  micro-op presented to the ALU stage.
- uop_ready  in  1  ALU stage consumes the micro-op.
- uop_vs1, uop_vs2, uop_vd  out  5 each  register indices of the current micro-op.
- uop_idx  out  3  position of the micro-op within the group, 0-based.
- uop_last  out  1  current micro-op is the final one of the group.
- fe_stall  out  1  stall request to the IF1/IF2 stages.
- illegal  out  1  one-cycle pulse marking a rejected instruction.

Function
REQ-004 The block SHALL implement a two-state FSM: IDLE (no micro-op held) and ISSUE (uop_valid=1).
REQ-005 Acceptance SHALL occur when in_valid && in_ready. in_ready SHALL be 1 in either case:
- state is IDLE;
- uop_valid && uop_ready && uop_last in the same cycle (back-to-back, no bubble).
REQ-006 On acceptance the block SHALL load the following registers and move to ISSUE with uop_valid=1 on the next cycle (1-cycle latency):
- uop_vs1/vs2/vd = in_vs1/vs2/vd;
- uop_idx = 0;
- remaining count = decoded LMUL - 1.
REQ-007 Reserved in_lmul encodings SHALL decode as LMUL=1. Decoded LMUL above MAX_LMUL SHALL be clamped to MAX_LMUL.
REQ-008 While uop_valid && !uop_ready, all uop_* outputs SHALL hold stable.
REQ-009 On each handshake (uop_valid && uop_ready) with uop_last=0, the block SHALL do all of the following:
- increment uop_vs1, uop_vs2 and uop_vd by 1, modulo 32 (31 wraps to 0);
- increment uop_idx by 1;
- decrement the remaining count by 1.
REQ-010 uop_last SHALL equal (remaining count == 0).
REQ-011 On a handshake with uop_last=1:
- if no new instruction is accepted that cycle, the FSM SHALL return to IDLE and uop_valid SHALL drop next cycle;
- if a new instruction is accepted in the same cycle, the new group SHALL take priority.
REQ-012 fe_stall SHALL equal !in_ready (combinational).
REQ-013 in_* inputs SHALL be ignored when not accepted.
REQ-014 illegal SHALL be 0 except as defined in REQ-018.

Reset
REQ-015 While rst=1, the outputs SHALL take these values:
- state = IDLE;
- uop_valid = 0, illegal = 0, in_ready = 1, fe_stall = 0;
- uop_vs1/vs2/vd = 0, uop_idx = 0, uop_last = 1, remaining count = 0.
REQ-016 Reset asserted mid-group SHALL abort the group immediately (asynchronously), with no further micro-ops issued and no resume.

Configuration
REQ-017 The macro VREG_GROUP_CHECK_EN SHALL compile in instruction legality checking.
REQ-018 With VREG_GROUP_CHECK_EN defined, an accepted instruction SHALL be illegal if either condition holds:
- in_lmul is a reserved encoding or decodes above MAX_LMUL;
- any of in_vs1, in_vs2 or in_vd is not a multiple of the decoded LMUL.
For an illegal instruction:
- no micro-op SHALL be issued and the FSM SHALL stay in IDLE;
- illegal SHALL pulse 1 on the cycle after acceptance.
REQ-019 Without VREG_GROUP_CHECK_EN, the following SHALL apply:
- no check is performed;
- illegal SHALL be tied to 0;
- REQ-007 decoding and REQ-009 wrap-around apply unconditionally.

Verification
REQ-020 The bench SHALL cover the following scenarios:
- LMUL=1: in_lmul=000, vs1=3, vs2=5, vd=7, uop_ready=1 -> one micro-op (3,5,7), idx=0, last=1; fe_stall=0 throughout.
- LMUL=4: in_lmul=010, vs1=8, vs2=12, vd=16, uop_ready=1 -> micro-ops (8,12,16)...(11,15,19) on 4 consecutive cycles; idx 0..3; last only on the 4th; fe_stall=1 for the first 3.
- Backpressure: LMUL=2 with uop_ready=0 for 3 cycles on idx 0 -> outputs held; then 2 micro-ops; in_ready=0 until the last handshake.
- Back-to-back: a second LMUL=2 instruction offered during the last micro-op of the first -> accepted in that cycle; its idx 0 appears the next cycle with no bubble.
- Reset mid-group: rst pulsed during idx 2 of an LMUL=8 group -> uop_valid=0 immediately; a following LMUL=1 instruction issues normally.
- Legality: with VREG_GROUP_CHECK_EN, LMUL=4 and vd=6 -> illegal pulse, no micro-op. Without the macro -> 4 micro-ops with vd 6..9. Also without the macro, LMUL=8 and vd=28 -> vd 28..31 then 0..3.
